// File: rtl/disp_frame_arbiter.sv
// disp_frame_arbiter: round-robin arbiter that shares one 3-digit 7-seg display
// between producer r0 (normal data) and producer r1 (alert/status). A granted
// frame owns the display for HOLD_MS ticks, then stays shown until the next grant.
// Optional feature: define DISP_BLINK_EN to blink the digit enables of r1 frames.
module disp_frame_arbiter #(
    parameter int unsigned TICK_DIV = 50000,
    parameter int unsigned HOLD_MS  = 500,
    parameter int unsigned BLINK_MS = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic [14:0] r0_hex,
    input  logic [2:0]  r0_dp,
    input  logic [2:0]  r0_en,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic [14:0] r1_hex,
    input  logic [2:0]  r1_dp,
    input  logic [2:0]  r1_en,
    output logic [4:0]  hex2,
    output logic [4:0]  hex1,
    output logic [4:0]  hex0,
    output logic [2:0]  dp_out,
    output logic [2:0]  en_out,
    output logic        owner,
    output logic        busy
);

    localparam int unsigned PrescW = $clog2(TICK_DIV);
    localparam int unsigned HoldW  = $clog2(HOLD_MS + 1);
    localparam logic [4:0]  CodeBlank = 5'h12;

    typedef enum logic {StIdle, StHold} state_e;

    state_e              state_q;
    logic                last_grant_q;
    logic [PrescW-1:0]   presc_q;
    logic [HoldW-1:0]    hold_q;
    logic                tick;
    logic                xfer;
    logic [14:0]         sel_hex;
    logic [2:0]          sel_dp;
    logic [2:0]          sel_en;

`ifdef DISP_BLINK_EN
    localparam int unsigned BlinkW = $clog2(BLINK_MS + 1);
    logic [2:0]          en_lat_q;
    logic                phase_q;
    logic [BlinkW-1:0]   blink_q;
`endif

    // Handshake decode: r0 wins unless r1 also requests and r0 was granted last.
    always_comb begin
        r0_ready = (state_q == StIdle) & r0_valid & (~r1_valid | last_grant_q);
        r1_ready = (state_q == StIdle) & r1_valid & (~r0_valid | ~last_grant_q);
        xfer     = r0_ready | r1_ready;
        tick     = (presc_q == PrescW'(TICK_DIV - 1));
        sel_hex  = r1_ready ? r1_hex : r0_hex;
        sel_dp   = r1_ready ? r1_dp  : r0_dp;
        sel_en   = r1_ready ? r1_en  : r0_en;
    end

    // Arbitration FSM, hold timing and registered display outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            presc_q      <= '0;
            hold_q       <= '0;
            hex2         <= CodeBlank;
            hex1         <= CodeBlank;
            hex0         <= CodeBlank;
            dp_out       <= 3'b000;
            en_out       <= 3'b000;
            owner        <= 1'b0;
            busy         <= 1'b0;
`ifdef DISP_BLINK_EN
            en_lat_q     <= 3'b000;
            phase_q      <= 1'b1;
            blink_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        state_q      <= StHold;
                        busy         <= 1'b1;
                        owner        <= r1_ready;
                        last_grant_q <= r1_ready;
                        hex2         <= sel_hex[14:10];
                        hex1         <= sel_hex[9:5];
                        hex0         <= sel_hex[4:0];
                        dp_out       <= sel_dp;
                        en_out       <= sel_en;
                        presc_q      <= '0;
                        hold_q       <= '0;
`ifdef DISP_BLINK_EN
                        en_lat_q     <= sel_en;
                        phase_q      <= 1'b1;
                        blink_q      <= '0;
                    end else begin
                        // Tick source keeps running so an r1 frame keeps blinking in IDLE.
                        presc_q <= tick ? '0 : presc_q + PrescW'(1);
`endif
                    end
                end
                StHold: begin
                    presc_q <= tick ? '0 : presc_q + PrescW'(1);
                    if (tick) begin
                        if (hold_q == HoldW'(HOLD_MS - 1)) begin
                            state_q <= StIdle;
                            busy    <= 1'b0;
                            hold_q  <= '0;
                        end else begin
                            hold_q <= hold_q + HoldW'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
`ifdef DISP_BLINK_EN
            // A transfer restarts the blink phase, so only count ticks between transfers.
            if (tick && !xfer) begin
                if (blink_q == BlinkW'(BLINK_MS - 1)) begin
                    blink_q <= '0;
                    phase_q <= ~phase_q;
                    if (owner) begin
                        en_out <= en_lat_q & {3{~phase_q}};
                    end
                end else begin
                    blink_q <= blink_q + BlinkW'(1);
                end
            end
`endif
        end
    end

endmodule
